ret_uart_reporter: RTL and testbench

//  Downstream consumer of the KGP RISC processor top level. Watches the 32-bit

---
 rtl/ret_uart_pkg.sv | 31 +++
 rtl/uart_tx_byte.sv | 61 ++++++
 rtl/ret_uart_reporter.sv | 120 ++++++++++++
 tb/tb_ret_uart_reporter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ret_uart_pkg.sv
// Shared types, ASCII constants and hex conversion for the return-value UART reporter.
// RET_UART_CRLF_EN selects 10-character frames (hex + CR LF) instead of 8.
package ret_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_A  = 8'h41;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;

`ifdef RET_UART_CRLF_EN
  localparam int CHARS_PER_FRAME = 10;
`else
  localparam int CHARS_PER_FRAME = 8;
`endif

  localparam logic [3:0] LAST_CHAR = 4'(CHARS_PER_FRAME - 1);

  function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
    if (n < 4'd10) return ASC_0 + {4'd0, n};
    else           return ASC_A + {4'd0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT clocks.
// o_done pulses during the final cycle of the stop bit.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_byte,
  input  logic       i_stb,
  output logic       o_tx,
  output logic       o_done
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic             r_tx;
  logic             r_active;
  logic [3:0]       r_bit_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [8:0]       r_shift;

  // bit index 0 = start, 1..8 = data, 9 = stop
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx      <= 1'b1;
      r_active  <= 1'b0;
      r_bit_idx <= 4'd0;
      r_cnt     <= '0;
    end else if (!r_active) begin
      if (i_stb) begin
        r_active  <= 1'b1;
        r_tx      <= 1'b0;
        r_bit_idx <= 4'd0;
        r_cnt     <= '0;
      end
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
      if (r_bit_idx == 4'd9) begin
        r_active <= 1'b0;
        r_tx     <= 1'b1;
      end else begin
        r_bit_idx <= r_bit_idx + 4'd1;
        r_tx      <= r_shift[0];
      end
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Shifter carries the stop bit in behind the data; no reset needed.
  always_ff @(posedge clk) begin
    if (!r_active && i_stb)
      r_shift <= {1'b1, i_byte};
    else if (r_active && r_cnt == CNT_MAX && r_bit_idx != 4'd9)
      r_shift <= {1'b1, r_shift[8:1]};
  end

  assign o_tx   = r_tx;
  assign o_done = r_active && (r_bit_idx == 4'd9) && (r_cnt == CNT_MAX);

endmodule

// File: rtl/ret_uart_reporter.sv
// Sends each new value of the processor return register as ASCII hex over 8N1 UART.
// Build option: RET_UART_CRLF_EN appends CR LF to every frame.
module ret_uart_reporter
  import ret_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int OVR_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ret_val,
  output logic             uart_tx,
  output logic             busy,
  output logic [OVR_W-1:0] overrun_cnt
);
  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_last_seen;
  logic [31:0]      r_pending;
  logic [31:0]      r_frame;
  logic             r_pending_vld;
  logic [OVR_W-1:0] r_overrun;
  logic [3:0]       r_char_idx;

  logic             w_change;
  logic             w_start;
  logic             w_consume;
  logic             w_last_char;
  logic             w_stb;
  logic             w_tx_done;
  logic [7:0]       w_char;

  assign w_change    = (ret_val != r_last_seen);
  assign w_start     = w_change && (r_state == ST_IDLE) && !r_pending_vld;
  assign w_consume   = (r_state == ST_DONE) && r_pending_vld;
  assign w_last_char = (r_char_idx == LAST_CHAR);

  // Index 0 selects bits 31:28, index 7 selects bits 3:0.
  always_comb begin
    w_char = nibble_to_hex(r_frame[{~r_char_idx[2:0], 2'b00} +: 4]);
`ifdef RET_UART_CRLF_EN
    if (r_char_idx == 4'd8)      w_char = ASC_CR;
    else if (r_char_idx == 4'd9) w_char = ASC_LF;
`endif
  end

  // Fixed overhead: NEXT and LOAD add exactly 2 idle-high cycles after every
  // stop bit, so one character occupies 10*CLKS_PER_BIT+2 clocks.
  always_comb begin
    w_state_nxt = r_state;
    w_stb       = 1'b0;
    unique case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        w_stb       = 1'b1;
        w_state_nxt = ST_SEND;
      end
      ST_SEND: if (w_tx_done) w_state_nxt = ST_NEXT;
      ST_NEXT: w_state_nxt = w_last_char ? ST_DONE : ST_LOAD;
      // A change arriving while DONE finds the slot empty is parked in pending;
      // DONE waits one cycle so it can pick it up without dropping busy.
      ST_DONE: begin
        if (r_pending_vld)  w_state_nxt = ST_LOAD;
        else if (w_change)  w_state_nxt = ST_DONE;
        else                w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_char_idx    <= 4'd0;
      r_last_seen   <= 32'd0;
      r_pending_vld <= 1'b0;
      r_overrun     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_NEXT)
        r_char_idx <= r_char_idx + 4'd1;
      else if (r_state == ST_IDLE || r_state == ST_DONE)
        r_char_idx <= 4'd0;
      if (w_change)
        r_last_seen <= ret_val;
      // A value consumed by DONE in this cycle is not counted as overwritten.
      if (w_change && !w_start) begin
        r_pending_vld <= 1'b1;
        if (r_pending_vld && !w_consume && r_overrun != '1)
          r_overrun <= r_overrun + OVR_W'(1);
      end else if (w_consume) begin
        r_pending_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_change && !w_start)
      r_pending <= ret_val;
    if (w_start)
      r_frame <= ret_val;
    else if (w_consume)
      r_frame <= r_pending;
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk   (clk),
    .rst   (rst),
    .i_byte(w_char),
    .i_stb (w_stb),
    .o_tx  (uart_tx),
    .o_done(w_tx_done)
  );

  assign busy        = (r_state != ST_IDLE);
  assign overrun_cnt = r_overrun;

endmodule

// File: tb/tb_ret_uart_reporter.sv
// Bench for ret_uart_reporter: timeline model of the serial line plus a UART receiver
// checking decoded bytes against hand-written strings.
module tb_ret_uart_reporter;
  localparam int C = 4;
  localparam int P = 10 * C + 2;
`ifdef RET_UART_CRLF_EN
  localparam int N = 10;
`else
  localparam int N = 8;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ret_val = 32'd0;
  logic        uart_tx;
  logic        busy;
  logic [7:0]  overrun_cnt;

  ret_uart_reporter #(.CLKS_PER_BIT(C), .OVR_W(8)) dut (
    .clk(clk), .rst(rst), .ret_val(ret_val),
    .uart_tx(uart_tx), .busy(busy), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  // Model: frames as (value, start edge); line level derived from the offset.
  bit          m_act, m_have, m_pv;
  int          m_s, m_done, m_ovr;
  logic [31:0] m_last, m_pend, m_frm;

  function automatic logic [7:0] hexc(input logic [31:0] v, input int j);
    int n;
    if (j == 8) return 8'h0D;
    if (j == 9) return 8'h0A;
    n = int'((v >> (28 - 4 * j)) & 32'hF);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  function automatic logic exp_tx(input int t);
    int o, j, r, b;
    logic [7:0] ch;
    if (!m_have || t < m_s) return 1'b1;
    o = t - m_s; j = o / P; r = o % P;
    if (j >= N || r >= 10 * C) return 1'b1;
    b = r / C;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    ch = hexc(m_frm, j);
    return ch[b-1];
  endfunction

  task automatic m_start(input logic [31:0] v);
    m_frm = v; m_s = cyc + 1; m_done = m_s + N * P; m_act = 1; m_have = 1;
  endtask

  initial forever begin : model
    bit was_act, opv, chg, consume;
    logic [31:0] op;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      chk_en = 1; m_act = 0; m_have = 0; m_pv = 0; m_ovr = 0; m_last = 0;
    end else begin
      was_act = m_act; opv = m_pv; op = m_pend;
      chg     = (ret_val !== m_last);
      consume = was_act && cyc >= m_done && opv;
      if (was_act && cyc >= m_done) begin
        if (opv) begin m_start(op); m_pv = 0; end
        else if (!chg) m_act = 0;
      end
      if (chg) begin
        m_last = ret_val;
        if (!was_act && !opv) m_start(ret_val);
        else begin
          if (opv && !consume && m_ovr < 255) m_ovr++;
          m_pend = ret_val; m_pv = 1;
        end
      end
    end
  end

  initial forever begin : compare
    @(negedge clk);
    if (chk_en) begin
      chk("uart_tx", {31'd0, uart_tx}, {31'd0, exp_tx(cyc)});
      chk("busy", {31'd0, busy}, {31'd0, m_act});
      chk("overrun_cnt", {24'd0, overrun_cnt}, m_ovr);
    end
  end

  // Independent receiver sampling mid-bit.
  logic [7:0] rxq[$];
  bit         rx_on = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte;
  initial forever begin : receiver
    @(negedge clk);
    if (!rx_on) begin
      if (chk_en && uart_tx === 1'b0) begin rx_on = 1; rx_cnt = 0; end
    end else begin
      rx_cnt++;
      if (rx_cnt % C == C / 2 && rx_cnt / C >= 1 && rx_cnt / C <= 8)
        rx_byte[rx_cnt / C - 1] = uart_tx;
      if (rx_cnt == 9 * C + C / 2) begin
        if (uart_tx === 1'b1) rxq.push_back(rx_byte);
        rx_on = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      step();
      if (!busy) break;
    end
    if (i == budget) begin
      nchk++; nerr++;
      $display("FAIL wait_idle timeout cyc=%0d got busy=%0b want 0", cyc, busy);
    end
  endtask

  task automatic wait_fall(output int t);
    int i;
    t = -1;
    for (i = 0; i < 3 * P; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin t = cyc; break; end
    end
  endtask

  task automatic chk_rx(input string name, input string hx);
    logic [7:0] ex[$];
    for (int i = 0; i < hx.len(); i++) begin
      ex.push_back(hx[i]);
`ifdef RET_UART_CRLF_EN
      if (i % 8 == 7) begin ex.push_back(8'h0D); ex.push_back(8'h0A); end
`endif
    end
    chk({name, "_len"}, rxq.size(), ex.size());
    for (int i = 0; i < ex.size() && i < rxq.size(); i++) chk(name, {24'd0, rxq[i]}, {24'd0, ex[i]});
    rxq.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int k, s, d, b;
    // reset held 3 cycles with ret_val=0; zero is never sent
    rst = 0; ret_val = 0;
    repeat (3) step();
    chk("rst_tx", {31'd0, uart_tx}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ovr", {24'd0, overrun_cnt}, 0);
    rst = 1;
    repeat (20) step();
    chk("no_start_bit", rxq.size(), 0);
    chk("idle_busy", {31'd0, busy}, 0);

    // single value, latency and decode
    ret_val = 32'h0000002A; k = cyc + 1;
    wait_fall(s);
    chk("latency_fall", s, k + 1);
    wait_idle(2000);
    chk_rx("frame_2A", "0000002A");

    // pending slot and overrun
    ret_val = 32'hDEADBEEF;
    repeat (50) step();
    ret_val = 32'd1; step();
    ret_val = 32'd2; step();
    ret_val = 32'd3; step();
    wait_idle(3000);
    chk("ovr_two", {24'd0, overrun_cnt}, 2);
    chk_rx("frames_db_3", "DEADBEEF00000003");

    // overrun saturation
    ret_val = 32'h00001000;
    repeat (10) step();
    for (int i = 0; i < 300; i++) begin ret_val = 32'h2000 + i; step(); end
    chk("ovr_sat", {24'd0, overrun_cnt}, 255);
    wait_idle(3000);
    chk_rx("frames_sat", "000010000000212B");

    // reset in the middle of char 3
    ret_val = 32'h12345678; k = cyc + 1; s = k + 1;
    wait_until(s + 3 * P + 20);
    rst = 0; ret_val = 0;
    step();
    chk("midrst_tx", {31'd0, uart_tx}, 1);
    chk("midrst_busy", {31'd0, busy}, 0);
    rst = 1;
    repeat (60) step();
    rx_on = 0; rxq.delete();
    ret_val = 32'hCAFE0001;
    repeat (2) step();
    wait_idle(2000);
    chk_rx("after_rst", "CAFE0001");

    // change arriving exactly when the frame is finishing
    ret_val = 32'h00000011; k = cyc + 1; s = k + 1; d = s + N * P;
    wait_until(d - 1);
    ret_val = 32'h00000022;
    step();
    wait_idle(3000);
    chk("b2b_ovr", {24'd0, overrun_cnt}, 0);
    chk_rx("back_to_back", "0000001100000022");

    // all-F frame and busy release after the last stop bit
    ret_val = 32'hFFFFFFFF;
    wait_fall(s);
    b = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) begin b = cyc; break; end
    end
    chk("busy_release", b - s, N * P);
    repeat (5) step();
    chk_rx("all_F", "FFFFFFFF");

    repeat (5) step();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end

endmodule
